alu_port_arbiter: RTL and testbench



---
 rtl/alu_port_arbiter.sv | 116 +++++++++++
 tb/tb_alu_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_port_arbiter.sv
// Two-port round-robin arbiter that sequences one shared ALU through
// EXEC (flag write), FLAG (flag capture) and RESP (one-cycle response).
module alu_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int FUN_W  = 5
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [FUN_W-1:0]  Req0FunSel,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    input  logic              Req0WF,

    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [FUN_W-1:0]  Req1FunSel,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    input  logic              Req1WF,

    output logic              Rsp0Valid,
    output logic [DATA_W-1:0] Rsp0Result,
    output logic [3:0]        Rsp0Flags,
    output logic              Rsp1Valid,
    output logic [DATA_W-1:0] Rsp1Result,
    output logic [3:0]        Rsp1Flags,

    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic [FUN_W-1:0]  AluFunSel,
    output logic              AluWF,
    input  logic [DATA_W-1:0] AluOut,
    input  logic [3:0]        AluFlags,

    output logic              Busy
);

    typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              grant;
    logic              grant_vld;
    logic [DATA_W-1:0] result_q;
    logic [3:0]        flags_q;

    // On a tie the port that did not win last time is favoured.
    always_comb begin
        grant_vld = Req0Valid | Req1Valid;
        if (Req0Valid && Req1Valid)
            grant = ~last_grant;
        else
            grant = Req1Valid;
    end

    assign Req0Ready  = (state == IDLE) && !Reset && grant_vld && !grant;
    assign Req1Ready  = (state == IDLE) && !Reset && grant_vld && grant;
    assign Busy       = (state != IDLE);
    assign Rsp0Result = result_q;
    assign Rsp1Result = result_q;
    assign Rsp0Flags  = flags_q;
    assign Rsp1Flags  = flags_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            AluA       <= '0;
            AluB       <= '0;
            AluFunSel  <= '0;
            AluWF      <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            Rsp0Valid  <= 1'b0;
            Rsp1Valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        AluA       <= grant ? Req1A      : Req0A;
                        AluB       <= grant ? Req1B      : Req0B;
                        AluFunSel  <= grant ? Req1FunSel : Req0FunSel;
                        AluWF      <= grant ? Req1WF     : Req0WF;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= AluOut;
                    AluWF    <= 1'b0;
                    state    <= FLAG;
                end
                // The ALU flag register has absorbed the EXEC write by now.
                FLAG: begin
                    flags_q   <= AluFlags;
                    Rsp0Valid <= ~owner;
                    Rsp1Valid <= owner;
                    state     <= RESP;
                end
                RESP: begin
                    Rsp0Valid <= 1'b0;
                    Rsp1Valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Directed bench for alu_port_arbiter with a small behavioural ALU
// (ADD/ADC/SUB/pass-A, flags {Z,C,N,O} registered on AluWF).
module tb_alu_port_arbiter;

    localparam logic [4:0] FS_PASS = 5'b10000;
    localparam logic [4:0] FS_ADD  = 5'b10100;
    localparam logic [4:0] FS_ADC  = 5'b10101;
    localparam logic [4:0] FS_SUB  = 5'b10110;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
    logic [4:0]  Req0FunSel, Req1FunSel;
    logic [15:0] Req0A, Req0B, Req1A, Req1B;
    logic        Req0WF, Req1WF;
    logic        Rsp0Valid, Rsp1Valid;
    logic [15:0] Rsp0Result, Rsp1Result;
    logic [3:0]  Rsp0Flags, Rsp1Flags;
    logic [15:0] AluA, AluB, AluOut;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [3:0]  AluFlags = 4'b0000;
    logic        Busy;

    int compared   = 0;
    int mismatched = 0;

    alu_port_arbiter #(.DATA_W(16), .FUN_W(5)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0FunSel(Req0FunSel),
        .Req0A(Req0A), .Req0B(Req0B), .Req0WF(Req0WF),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1FunSel(Req1FunSel),
        .Req1A(Req1A), .Req1B(Req1B), .Req1WF(Req1WF),
        .Rsp0Valid(Rsp0Valid), .Rsp0Result(Rsp0Result), .Rsp0Flags(Rsp0Flags),
        .Rsp1Valid(Rsp1Valid), .Rsp1Result(Rsp1Result), .Rsp1Flags(Rsp1Flags),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Behavioural ALU; its flag register is deliberately not tied to Reset.
    logic [16:0] aluSum;
    logic        aluC, aluO;
    always_comb begin
        aluSum = 17'(AluA);
        aluC   = AluFlags[2];
        aluO   = AluFlags[0];
        case (AluFunSel)
            FS_ADD: begin
                aluSum = {1'b0, AluA} + {1'b0, AluB};
                aluC   = aluSum[16];
                aluO   = (AluA[15] == AluB[15]) && (aluSum[15] != AluA[15]);
            end
            FS_ADC: begin
                aluSum = {1'b0, AluA} + {1'b0, AluB} + {16'b0, AluFlags[2]};
                aluC   = aluSum[16];
                aluO   = (AluA[15] == AluB[15]) && (aluSum[15] != AluA[15]);
            end
            FS_SUB: begin
                aluSum = {1'b0, AluA} - {1'b0, AluB};
                aluC   = aluSum[16];
                aluO   = (AluA[15] != AluB[15]) && (aluSum[15] != AluA[15]);
            end
            default: ;
        endcase
        AluOut = aluSum[15:0];
    end

    always_ff @(posedge Clock)
        if (AluWF) AluFlags <= {AluOut == 16'h0000, aluC, AluOut[15], aluO};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one op on a port from an IDLE negedge and follows it to the next IDLE.
    task automatic applyStimulus(input int port, input logic [4:0] fs,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic wf, input logic [15:0] expRes,
                                 input logic [3:0] expFlags, input string tag);
        if (port == 0) begin
            Req0Valid = 1'b1; Req0FunSel = fs; Req0A = a; Req0B = b; Req0WF = wf;
        end else begin
            Req1Valid = 1'b1; Req1FunSel = fs; Req1A = a; Req1B = b; Req1WF = wf;
        end
        #1;
        checkOutput({tag, " ready"}, 32'(port == 0 ? Req0Ready : Req1Ready), 1);
        checkOutput({tag, " other ready"}, 32'(port == 0 ? Req1Ready : Req0Ready), 0);
        checkOutput({tag, " busy idle"}, 32'(Busy), 0);
        @(negedge Clock);
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        checkOutput({tag, " exec wf"}, 32'(AluWF), 32'(wf));
        checkOutput({tag, " exec A"}, 32'(AluA), 32'(a));
        checkOutput({tag, " exec funsel"}, 32'(AluFunSel), 32'(fs));
        checkOutput({tag, " exec busy"}, 32'(Busy), 1);
        @(negedge Clock);
        checkOutput({tag, " flag wf"}, 32'(AluWF), 0);
        checkOutput({tag, " flag rsp"}, 32'(Rsp0Valid | Rsp1Valid), 0);
        @(negedge Clock);
        checkOutput({tag, " rsp valid"}, 32'(port == 0 ? Rsp0Valid : Rsp1Valid), 1);
        checkOutput({tag, " other rsp"}, 32'(port == 0 ? Rsp1Valid : Rsp0Valid), 0);
        checkOutput({tag, " result"}, 32'(port == 0 ? Rsp0Result : Rsp1Result), 32'(expRes));
        checkOutput({tag, " flags"}, 32'(port == 0 ? Rsp0Flags : Rsp1Flags), 32'(expFlags));
        checkOutput({tag, " rsp wf"}, 32'(AluWF), 0);
        @(negedge Clock);
        checkOutput({tag, " done rsp"}, 32'(Rsp0Valid | Rsp1Valid), 0);
        checkOutput({tag, " done busy"}, 32'(Busy), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        realtime lastAccept;
        Reset = 1'b1;
        Req0Valid = 0; Req1Valid = 0;
        Req0FunSel = '0; Req1FunSel = '0;
        Req0A = '0; Req0B = '0; Req1A = '0; Req1B = '0;
        Req0WF = 0; Req1WF = 0;
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("reset AluA", 32'(AluA), 0);
        checkOutput("reset AluB", 32'(AluB), 0);
        checkOutput("reset AluFunSel", 32'(AluFunSel), 0);
        checkOutput("reset AluWF", 32'(AluWF), 0);
        checkOutput("reset Busy", 32'(Busy), 0);
        checkOutput("reset Rsp0", 32'({Rsp0Valid, Rsp0Result, Rsp0Flags}), 0);
        checkOutput("reset Rsp1", 32'({Rsp1Valid, Rsp1Result, Rsp1Flags}), 0);
        Reset = 1'b0;

        // Single op: 7FFF + 1 -> 8000, {Z,C,N,O} = 0011
        applyStimulus(0, FS_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0011, "t1");

        // Both ports continuously valid from reset: 0,1,0,1 each 4 cycles apart
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Req0Valid = 1; Req0FunSel = FS_ADD; Req0A = 16'h0100; Req0B = 16'h0011; Req0WF = 1;
        Req1Valid = 1; Req1FunSel = FS_ADD; Req1A = 16'h0200; Req1B = 16'h0022; Req1WF = 1;
        lastAccept = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("t2 ready0 op%0d", k), 32'(Req0Ready), 32'(k % 2 == 0));
            checkOutput($sformatf("t2 ready1 op%0d", k), 32'(Req1Ready), 32'(k % 2 == 1));
            if (k > 0)
                checkOutput($sformatf("t2 spacing op%0d", k), 32'(int'($realtime - lastAccept)), 40);
            lastAccept = $realtime;
            for (int c = 0; c < 3; c++) begin
                @(negedge Clock);
                checkOutput($sformatf("t2 both ready op%0d c%0d", k, c), 32'(Req0Ready & Req1Ready), 0);
            end
            if (k % 2 == 0) begin
                checkOutput($sformatf("t2 rsp0 op%0d", k), 32'(Rsp0Valid), 1);
                checkOutput($sformatf("t2 result0 op%0d", k), 32'(Rsp0Result), 32'h0111);
            end else begin
                checkOutput($sformatf("t2 rsp1 op%0d", k), 32'(Rsp1Valid), 1);
                checkOutput($sformatf("t2 result1 op%0d", k), 32'(Rsp1Result), 32'h0222);
            end
            @(negedge Clock);
        end
        Req0Valid = 0; Req1Valid = 0;

        // Flags set by port 0, then a WF=0 pass on port 1 sees them unchanged
        applyStimulus(0, FS_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1100, "t3a");
        applyStimulus(1, FS_PASS, 16'h1234, 16'h0000, 1'b0, 16'h1234, 4'b1100, "t3b");

        // Reset arrives mid-EXEC of a port 1 flag-writing op
        Req1Valid = 1; Req1FunSel = FS_ADD; Req1A = 16'h0F0F; Req1B = 16'h0001; Req1WF = 1;
        @(negedge Clock);
        Req1Valid = 0;
        checkOutput("t4 exec wf", 32'(AluWF), 1);
        Reset = 1'b1;
        #1;
        checkOutput("t4 rst AluWF", 32'(AluWF), 0);
        checkOutput("t4 rst Alu operands", 32'({AluA, AluB}), 0);
        checkOutput("t4 rst AluFunSel", 32'(AluFunSel), 0);
        checkOutput("t4 rst Busy", 32'(Busy), 0);
        checkOutput("t4 rst Rsp1", 32'({Rsp1Valid, Rsp1Result, Rsp1Flags}), 0);
        @(negedge Clock);
        checkOutput("t4 flags kept", 32'(AluFlags), 32'b1100);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            checkOutput($sformatf("t4 no rsp1 c%0d", c), 32'(Rsp1Valid), 0);
        end
        Req0Valid = 1; Req0FunSel = FS_ADD; Req0A = 16'h0040; Req0B = 16'h0002; Req0WF = 1;
        Req1Valid = 1; Req1FunSel = FS_ADD; Req1A = 16'h0300; Req1B = 16'h0003; Req1WF = 1;
        #1;
        checkOutput("t4 tie ready0", 32'(Req0Ready), 1);
        checkOutput("t4 tie ready1", 32'(Req1Ready), 0);
        @(negedge Clock);
        Req0Valid = 0; Req1Valid = 0;
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("t4 tie rsp0", 32'(Rsp0Valid), 1);
        checkOutput("t4 tie result", 32'(Rsp0Result), 32'h0042);
        @(negedge Clock);

        // Port 1 shows up during port 0's FLAG cycle
        Req0Valid = 1; Req0FunSel = FS_ADD; Req0A = 16'h0005; Req0B = 16'h0003; Req0WF = 1;
        @(negedge Clock);
        Req0Valid = 0;
        @(negedge Clock);
        Req1Valid = 1; Req1FunSel = FS_ADD; Req1A = 16'h0010; Req1B = 16'h0020; Req1WF = 1;
        #1;
        checkOutput("t5 flag ready1", 32'(Req1Ready), 0);
        @(negedge Clock);
        checkOutput("t5 resp ready1", 32'(Req1Ready), 0);
        checkOutput("t5 rsp0", 32'(Rsp0Valid), 1);
        checkOutput("t5 result0", 32'(Rsp0Result), 32'h0008);
        @(negedge Clock);
        applyStimulus(1, FS_ADD, 16'h0010, 16'h0020, 1'b1, 16'h0030, 4'b0000, "t5b");

        // Port 0 alone, valid every cycle
        Req0Valid = 1; Req0FunSel = FS_ADD; Req0A = 16'h0001; Req0B = 16'h0001; Req0WF = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            checkOutput($sformatf("t6 ready0 c%0d", c), 32'(Req0Ready), 32'(c % 4 == 0));
            checkOutput($sformatf("t6 busy c%0d", c), 32'(Busy), 32'(c % 4 != 0));
            checkOutput($sformatf("t6 rsp0 c%0d", c), 32'(Rsp0Valid), 32'(c % 4 == 3));
            if (c % 4 == 3)
                checkOutput($sformatf("t6 result c%0d", c), 32'(Rsp0Result), 32'h0002);
            @(negedge Clock);
        end
        Req0Valid = 0;
        @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
